// File: rtl/ahb_generic_arbiter.sv
// ahb_generic_arbiter
//   Single-layer AHB interconnect core: fixed-priority arbiter with lock/burst
//   hold, master-to-slave address/control/write-data mux, address decoder and
//   slave-to-master response mux.
//
// Ports
//   hclk, hreset          clock, synchronous active-high reset
//   m_busreq, m_hlock     per-master request and locked-transfer request
//   m_haddr .. m_hwdata   packed per-master AHB address/control/write data
//   hgrant                one-hot grant (next address-phase owner)
//   s_hmaster             current address-phase owner index
//   s_hmaster_lock        locked-sequence indicator
//   s_addr_out .. s_hwrite  address/control of the address-phase owner
//   s_data_out            write data of the data-phase owner
//   s_hsel                one-hot slave select decoded from s_addr_out
//   s_hready/hresp/hrdata per-slave responses
//   m_hready/hresp/hrdata response of the data-phase slave, broadcast
module ahb_generic_arbiter #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned NUM_SLAVES  = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input  logic                          hclk,
   input  logic                          hreset,
   input  logic [NUM_MASTERS-1:0]        m_busreq,
   input  logic [NUM_MASTERS-1:0]        m_hlock,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
   input  logic [NUM_MASTERS*2-1:0]      m_htrans,
   input  logic [NUM_MASTERS*3-1:0]      m_hburst,
   input  logic [NUM_MASTERS*3-1:0]      m_hsize,
   input  logic [NUM_MASTERS-1:0]        m_hwrite,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
   output logic [NUM_MASTERS-1:0]        hgrant,
   output logic [3:0]                    s_hmaster,
   output logic                          s_hmaster_lock,
   output logic [ADDR_W-1:0]             s_addr_out,
   output logic [1:0]                    s_htrans_out,
   output logic [2:0]                    s_hburst_out,
   output logic [2:0]                    s_hsize,
   output logic                          s_hwrite,
   output logic [DATA_W-1:0]             s_data_out,
   output logic [NUM_SLAVES-1:0]         s_hsel,
   input  logic [NUM_SLAVES-1:0]         s_hready,
   input  logic [NUM_SLAVES*2-1:0]       s_hresp,
   input  logic [NUM_SLAVES*DATA_W-1:0]  s_hrdata,
   output logic                          m_hready,
   output logic [1:0]                    m_hresp,
   output logic [DATA_W-1:0]             m_hrdata
);

   localparam int unsigned MW = $clog2(NUM_MASTERS);
   localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   localparam logic [1:0] HTRANS_BUSY = 2'd1;
   localparam logic [1:0] HTRANS_SEQ  = 2'd3;

   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [MW-1:0]          amaster_q, dmaster_q, grant_idx;
   logic                   lock_q;
   logic [SW-1:0]          dslave_q, aslave;
   logic                   owner_lock, grant_lock, owner_hold;

   // Index of the granted master plus its lock request
   always_comb begin
      grant_idx  = '0;
      grant_lock = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            grant_idx  = MW'(i);
            grant_lock = m_hlock[i];
         end
      end
   end

   // Address/control mux for the address-phase owner
   always_comb begin
      s_addr_out   = '0;
      s_htrans_out = '0;
      s_hburst_out = '0;
      s_hsize      = '0;
      s_hwrite     = 1'b0;
      owner_lock   = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (amaster_q == MW'(i)) begin
            s_addr_out   = m_haddr[i*ADDR_W +: ADDR_W];
            s_htrans_out = m_htrans[i*2 +: 2];
            s_hburst_out = m_hburst[i*3 +: 3];
            s_hsize      = m_hsize[i*3 +: 3];
            s_hwrite     = m_hwrite[i];
            owner_lock   = m_hlock[i];
         end
      end
   end

   // Write data follows the data-phase owner
   always_comb begin
      s_data_out = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (dmaster_q == MW'(i)) s_data_out = m_hwdata[i*DATA_W +: DATA_W];
      end
   end

   // Decoder: top address bits pick the slave; not gated by htrans
   if (NUM_SLAVES > 1) begin : g_dec
      assign aslave = s_addr_out[ADDR_W-1 -: SW];
   end else begin : g_dec_single
      assign aslave = 1'b0;
   end
   assign s_hsel = NUM_SLAVES'(1) << aslave;

   // Response mux driven by the slave of the previous address phase
   always_comb begin
      m_hready = 1'b0;
      m_hresp  = '0;
      m_hrdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (dslave_q == SW'(i)) begin
            m_hready = s_hready[i];
            m_hresp  = s_hresp[i*2 +: 2];
            m_hrdata = s_hrdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next grant: the owner keeps the bus while locked or mid-burst;
   // otherwise lowest requesting index wins, master 0 by default
   assign owner_hold = owner_lock || (s_htrans_out == HTRANS_BUSY) ||
                       (s_htrans_out == HTRANS_SEQ);

   always_comb begin
      grant_d = NUM_MASTERS'(1);
      if (owner_hold) begin
         grant_d = grant_q;
      end else begin
         // Descending scan so the lowest index is assigned last
         for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_busreq[i]) grant_d = NUM_MASTERS'(1) << i;
         end
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         grant_q   <= NUM_MASTERS'(1);
         amaster_q <= '0;
         lock_q    <= 1'b0;
         dmaster_q <= '0;
         dslave_q  <= '0;
      end else if (m_hready) begin
         grant_q   <= grant_d;
         amaster_q <= grant_idx;
         lock_q    <= grant_lock;
         dmaster_q <= amaster_q;
         dslave_q  <= aslave;
      end
   end

   assign hgrant         = grant_q;
   assign s_hmaster      = 4'(amaster_q);
   assign s_hmaster_lock = lock_q;

endmodule

// File: tb/tb_ahb_generic_arbiter.sv
module tb_ahb_generic_arbiter;
   localparam int NM = 4;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SB = $clog2(NS);

   logic              hclk = 1'b0;
   logic              hreset;
   logic [NM-1:0]     m_busreq, m_hlock, m_hwrite;
   logic [NM*AW-1:0]  m_haddr;
   logic [NM*2-1:0]   m_htrans;
   logic [NM*3-1:0]   m_hburst, m_hsize;
   logic [NM*DW-1:0]  m_hwdata;
   logic [NM-1:0]     hgrant;
   logic [3:0]        s_hmaster;
   logic              s_hmaster_lock;
   logic [AW-1:0]     s_addr_out;
   logic [1:0]        s_htrans_out;
   logic [2:0]        s_hburst_out, s_hsize;
   logic              s_hwrite;
   logic [DW-1:0]     s_data_out;
   logic [NS-1:0]     s_hsel, s_hready;
   logic [NS*2-1:0]   s_hresp;
   logic [NS*DW-1:0]  s_hrdata;
   logic              m_hready;
   logic [1:0]        m_hresp;
   logic [DW-1:0]     m_hrdata;

   int checks = 0;
   int errors = 0;

   // Reference model: grant, address owner, lock, data owner, data slave
   int mg = 0, mo = 0, ml = 0, md = 0, ms = 0;

   ahb_generic_arbiter #(
      .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)
   ) dut (
      .hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock),
      .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hburst(m_hburst), .m_hsize(m_hsize),
      .m_hwrite(m_hwrite), .m_hwdata(m_hwdata), .hgrant(hgrant), .s_hmaster(s_hmaster),
      .s_hmaster_lock(s_hmaster_lock), .s_addr_out(s_addr_out),
      .s_htrans_out(s_htrans_out), .s_hburst_out(s_hburst_out), .s_hsize(s_hsize),
      .s_hwrite(s_hwrite), .s_data_out(s_data_out), .s_hsel(s_hsel),
      .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
      .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata)
   );

   always #5 hclk = ~hclk;

   function automatic logic [AW-1:0] addr_of(int i);
      return m_haddr[i*AW +: AW];
   endfunction

   function automatic int trans_of(int i);
      return int'(m_htrans[i*2 +: 2]);
   endfunction

   function automatic int slave_of(logic [AW-1:0] a);
      return int'(a >> (AW - SB));
   endfunction

   // Owner keeps the bus while locked or in BUSY/SEQ; else lowest requester
   function automatic int next_grant();
      if (m_hlock[mo] || trans_of(mo) == 1 || trans_of(mo) == 3) return mg;
      for (int i = 0; i < NM; i++) if (m_busreq[i]) return i;
      return 0;
   endfunction

   // One clock edge; the model advances from the pre-edge inputs
   task automatic tick();
      bit rst, rdy;
      int ng, nsl, nlk;
      rst = hreset;
      rdy = s_hready[ms];
      ng  = next_grant();
      nsl = slave_of(addr_of(mo));
      nlk = int'(m_hlock[mg]);
      @(posedge hclk);
      if (rst) begin
         mg = 0; mo = 0; ml = 0; md = 0; ms = 0;
      end else if (rdy) begin
         md = mo; ms = nsl; ml = nlk; mo = mg; mg = ng;
      end
      #1;
   endtask

   task automatic clear_masters();
      m_busreq = '0; m_hlock = '0; m_hwrite = '0; m_haddr = '0;
      m_htrans = '0; m_hburst = '0; m_hsize = '0; m_hwdata = '0;
   endtask

   task automatic test_reset();
      clear_masters();
      s_hready = '1; s_hresp = '0; s_hrdata = '0;
      hreset = 1'b1;
      tick(); tick();
      hreset = 1'b0;
      #1;
      checks++; if (hgrant !== 4'b0001) begin errors++;
         $display("FAIL reset_hgrant got %b exp 0001", hgrant); end
      checks++; if (s_hmaster !== 4'd0) begin errors++;
         $display("FAIL reset_hmaster got %0d exp 0", s_hmaster); end
      checks++; if (s_hmaster_lock !== 1'b0) begin errors++;
         $display("FAIL reset_lock got %b exp 0", s_hmaster_lock); end
      checks++; if (s_hsel !== 4'b0001) begin errors++;
         $display("FAIL reset_hsel got %b exp 0001", s_hsel); end
   endtask

   task automatic test_single_write();
      m_busreq[2] = 1'b1; m_hlock[2] = 1'b1;
      m_haddr[2*AW +: AW] = 50; m_htrans[2*2 +: 2] = 2'd2;
      m_hsize[2*3 +: 3] = 3'd2; m_hwrite[2] = 1'b1; m_hwdata[2*DW +: DW] = 20;
      tick();
      checks++; if (hgrant !== 4'b0100) begin errors++;
         $display("FAIL write_hgrant got %b exp 0100", hgrant); end
      tick();
      checks++; if (s_hmaster !== 4'd2) begin errors++;
         $display("FAIL write_hmaster got %0d exp 2", s_hmaster); end
      checks++; if (s_addr_out !== 32'd50) begin errors++;
         $display("FAIL write_addr got %0d exp 50", s_addr_out); end
      checks++; if (s_hsel !== 4'b0001) begin errors++;
         $display("FAIL write_hsel got %b exp 0001", s_hsel); end
      checks++; if (s_hmaster_lock !== 1'b1) begin errors++;
         $display("FAIL write_lock got %b exp 1", s_hmaster_lock); end
      checks++; if (s_hwrite !== 1'b1 || s_hsize !== 3'd2 || s_htrans_out !== 2'd2) begin
         errors++;
         $display("FAIL write_ctrl got w=%b sz=%0d tr=%0d exp w=1 sz=2 tr=2",
                  s_hwrite, s_hsize, s_htrans_out); end
      tick();
      checks++; if (s_data_out !== 32'd20) begin errors++;
         $display("FAIL write_data got %0d exp 20", s_data_out); end
      clear_masters();
      tick();
   endtask

   task automatic test_priority();
      m_busreq[1] = 1'b1; m_busreq[3] = 1'b1;
      tick();
      checks++; if (hgrant !== 4'b0010) begin errors++;
         $display("FAIL prio_both got %b exp 0010", hgrant); end
      m_busreq[1] = 1'b0;
      tick();
      checks++; if (hgrant !== 4'b1000) begin errors++;
         $display("FAIL prio_drop got %b exp 1000", hgrant); end
   endtask

   task automatic test_lock_hold();
      m_hlock[3] = 1'b1; m_htrans[3*2 +: 2] = 2'd2;
      tick();
      m_busreq[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (hgrant !== 4'b1000) begin errors++;
            $display("FAIL lock_hold[%0d] got %b exp 1000", k, hgrant); end
      end
      checks++; if (s_hmaster !== 4'd3 || s_hmaster_lock !== 1'b1) begin errors++;
         $display("FAIL lock_owner got m=%0d l=%b exp m=3 l=1", s_hmaster, s_hmaster_lock); end
      // Lock dropped but burst still in SEQ: keep the bus
      m_hlock[3] = 1'b0; m_htrans[3*2 +: 2] = 2'd3;
      tick();
      checks++; if (hgrant !== 4'b1000) begin errors++;
         $display("FAIL lock_seq got %b exp 1000", hgrant); end
      m_htrans[3*2 +: 2] = 2'd0;
      tick();
      checks++; if (hgrant !== 4'b0001) begin errors++;
         $display("FAIL lock_release got %b exp 0001", hgrant); end
   endtask

   task automatic test_wait_state();
      clear_masters();
      m_haddr[0 +: AW] = 32'h4000_0000; m_htrans[0 +: 2] = 2'd2;
      s_hrdata[1*DW +: DW] = 32'hA5A5_A5A5; s_hresp[1*2 +: 2] = 2'd1;
      tick(); tick();
      s_hready[1] = 1'b0;
      m_busreq[2] = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (m_hready !== 1'b0) begin errors++;
            $display("FAIL wait_hready[%0d] got %b exp 0", k, m_hready); end
         checks++; if (hgrant !== 4'b0001 || s_hmaster !== 4'd0) begin errors++;
            $display("FAIL wait_frozen[%0d] got g=%b m=%0d exp g=0001 m=0", k, hgrant, s_hmaster);
         end
         checks++; if (m_hrdata !== 32'hA5A5_A5A5 || m_hresp !== 2'd1) begin errors++;
            $display("FAIL wait_resp[%0d] got d=%h r=%0d exp d=a5a5a5a5 r=1", k, m_hrdata, m_hresp);
         end
         tick();
      end
      s_hready = '1;
      #1;
      tick();
      checks++; if (hgrant !== 4'b0100) begin errors++;
         $display("FAIL wait_resume got %b exp 0100", hgrant); end
   endtask

   task automatic test_idle();
      clear_masters();
      tick(); tick(); tick();
      checks++; if (hgrant !== 4'b0001 || s_hmaster !== 4'd0) begin errors++;
         $display("FAIL idle got g=%b m=%0d exp g=0001 m=0", hgrant, s_hmaster); end
   endtask

   task automatic test_random();
      logic [NM-1:0] eg;
      logic [NS-1:0] es;
      for (int c = 0; c < 3000; c++) begin
         m_busreq = NM'($urandom);
         m_hlock  = ($urandom_range(0, 3) == 0) ? NM'($urandom) : '0;
         m_hwrite = NM'($urandom);
         for (int i = 0; i < NM; i++) begin
            m_haddr[i*AW +: AW]  = $urandom;
            m_htrans[i*2 +: 2]   = 2'($urandom);
            m_hburst[i*3 +: 3]   = 3'($urandom);
            m_hsize[i*3 +: 3]    = 3'($urandom);
            m_hwdata[i*DW +: DW] = $urandom;
         end
         for (int j = 0; j < NS; j++) begin
            s_hready[j]            = ($urandom_range(0, 3) != 0);
            s_hresp[j*2 +: 2]      = 2'($urandom);
            s_hrdata[j*DW +: DW]   = $urandom;
         end
         hreset = ($urandom_range(0, 63) == 0);
         #1;
         eg = NM'(1) << mg;
         es = NS'(1) << slave_of(addr_of(mo));
         checks++; if (hgrant !== eg) begin errors++;
            $display("FAIL rnd_hgrant c=%0d got %b exp %b", c, hgrant, eg); end
         checks++; if (s_hmaster !== 4'(mo) || s_hmaster_lock !== 1'(ml)) begin errors++;
            $display("FAIL rnd_owner c=%0d got m=%0d l=%b exp m=%0d l=%0d",
                     c, s_hmaster, s_hmaster_lock, mo, ml); end
         checks++; if (s_addr_out !== addr_of(mo) || s_htrans_out !== m_htrans[mo*2 +: 2] ||
                       s_hburst_out !== m_hburst[mo*3 +: 3] || s_hsize !== m_hsize[mo*3 +: 3] ||
                       s_hwrite !== m_hwrite[mo]) begin errors++;
            $display("FAIL rnd_addrctl c=%0d got a=%h t=%0d exp a=%h t=%0d owner=%0d",
                     c, s_addr_out, s_htrans_out, addr_of(mo), m_htrans[mo*2 +: 2], mo); end
         checks++; if (s_data_out !== m_hwdata[md*DW +: DW]) begin errors++;
            $display("FAIL rnd_wdata c=%0d got %h exp %h", c, s_data_out, m_hwdata[md*DW +: DW]);
         end
         checks++; if (s_hsel !== es) begin errors++;
            $display("FAIL rnd_hsel c=%0d got %b exp %b", c, s_hsel, es); end
         checks++; if (m_hready !== s_hready[ms] || m_hresp !== s_hresp[ms*2 +: 2] ||
                       m_hrdata !== s_hrdata[ms*DW +: DW]) begin errors++;
            $display("FAIL rnd_resp c=%0d got rdy=%b r=%0d d=%h exp slave %0d",
                     c, m_hready, m_hresp, m_hrdata, ms); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_priority();
      test_lock_hold();
      test_wait_state();
      test_idle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
